// File: rtl/signed_adder_scan_display_pkg.sv
// Shared constants for the signed adder / scanned 7-segment display path.
// Segment codes are active-low, bit order {g,f,e,d,c,b,a}.
package signed_adder_scan_display_pkg;

  localparam logic [15:0][6:0] SEG_TBL = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  localparam logic [6:0]  SEG_BLANK    = 7'h7F;
  localparam logic [31:0] ANODE_DIGIT0 = ~32'd1;

  function automatic int idx_w(input int digits);
    return (digits <= 1) ? 1 : $clog2(digits);
  endfunction

endpackage

// File: rtl/signed_adder_scan_display_nibble_seg_decode.sv
// Hex nibble to active-low 7-segment code, purely combinational.
module nibble_seg_decode
  import signed_adder_scan_display_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TBL[nib_i];

endmodule

// File: rtl/signed_adder_scan_display.sv
// Registered signed add/sub with overflow, shown sign-magnitude on a scanned
// active-low hex display. Define OVF_BLINK_EN to blink the display on overflow.
module signed_adder_scan_display
  import signed_adder_scan_display_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int DIGITS       = 4,
  parameter int REFRESH_BITS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  input  logic              Sub,
  input  logic              Load,
  output logic [WIDTH-1:0]  Sum,
  output logic              OverFlow,
  output logic [6:0]        segs7,
  output logic [DIGITS-1:0] Anodes,
  output logic              period
);

  localparam int IW = idx_w(DIGITS);

  logic [WIDTH-1:0]        sum_q, sum_d;
  logic                    ovf_q, ovf_d;
  logic [REFRESH_BITS-1:0] pre_q;
  logic [IW-1:0]           idx_q, idx_d;
  logic [DIGITS-1:0]       an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;

  // Subtract as A + ~B + 1; overflow judged on the post-inversion B sign.
  logic [WIDTH-1:0] b_eff, res;
  assign b_eff = Sub ? ~B : B;
  assign res   = A + b_eff + WIDTH'(Sub);

  always_comb begin
    sum_d = sum_q;
    ovf_d = ovf_q;
    if (Load) begin
      sum_d = res;
      ovf_d = (A[WIDTH-1] == b_eff[WIDTH-1]) && (res[WIDTH-1] != A[WIDTH-1]);
    end
  end

  logic             neg;
  logic [WIDTH-1:0] mag;
  assign neg = sum_q[WIDTH-1];
  assign mag = neg ? -sum_q : sum_q;

  logic [DIGITS*4-1:0] mag_ext;
  always_comb begin
    mag_ext = '0;
    mag_ext[WIDTH-1:0] = mag;
  end

  logic       wrap, last_dig, blank;
  logic [3:0] nib;
  logic [6:0] dec_seg;
  assign wrap     = &pre_q;
  assign last_dig = (idx_q == IW'(DIGITS - 1));
  assign nib      = mag_ext[int'(idx_q)*4 +: 4];
  assign blank    = (int'(idx_q) * 4 >= WIDTH);

  nibble_seg_decode u_dec (
    .nib_i (nib),
    .seg_o (dec_seg)
  );

  always_comb begin
    idx_d = idx_q;
    if (wrap) idx_d = last_dig ? '0 : idx_q + 1'b1;
  end

  logic blink_off;
`ifdef OVF_BLINK_EN
  logic [3:0] blink_q;
  always_ff @(posedge clk) begin
    if (reset)                 blink_q <= '0;
    else if (wrap && last_dig) blink_q <= blink_q + 1'b1;
  end
  assign blink_off = ovf_q & blink_q[3];
`else
  assign blink_off = 1'b0;
`endif

  // Display registers follow the index one cycle later; anode never blanks.
  always_comb begin
    an_d  = ~(DIGITS'(1) << idx_q);
    seg_d = (blank || blink_off) ? SEG_BLANK : dec_seg;
    dp_d  = (idx_q == '0 && !blink_off) ? ~neg : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
      ovf_q <= 1'b0;
      pre_q <= '0;
      idx_q <= '0;
      an_q  <= ANODE_DIGIT0[DIGITS-1:0];
      seg_q <= SEG_TBL[0];
      dp_q  <= 1'b1;
    end else begin
      sum_q <= sum_d;
      ovf_q <= ovf_d;
      pre_q <= pre_q + 1'b1;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign Sum      = sum_q;
  assign OverFlow = ovf_q;
  assign Anodes   = an_q;
  assign segs7    = seg_q;
  assign period   = dp_q;

endmodule

// File: tb/tb_signed_adder_scan_display.sv
// Directed bench: adder results, overflow, digit contents, sign point, reset.
module tb_signed_adder_scan_display;

  logic       clk = 1'b0;
  logic       reset, Sub, Load;
  logic [7:0] A, B, Sum;
  logic       OverFlow, period;
  logic [6:0] segs7;
  logic [3:0] Anodes;

  int total = 0;
  int bad   = 0;

  signed_adder_scan_display #(.WIDTH(8), .DIGITS(4), .REFRESH_BITS(2)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .Sub(Sub), .Load(Load),
    .Sum(Sum), .OverFlow(OverFlow), .segs7(segs7), .Anodes(Anodes),
    .period(period)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic load_op(input logic [7:0] a, input logic [7:0] b, input logic s);
    A = a; B = b; Sub = s; Load = 1'b1;
    tick(1);
    Load = 1'b0;
  endtask

  // Bounded wait until digit k is being driven, then check its segments and point.
  task automatic show(input string tag, input int k, input logic [6:0] seg, input logic dp);
    logic [3:0] pat;
    pat = ~(4'b0001 << k);
    for (int i = 0; i < 64; i++) begin
      if (Anodes === pat) break;
      tick(1);
    end
    chk({tag, "_anode"}, 32'(Anodes), 32'(pat));
    chk({tag, "_seg"}, 32'(segs7), 32'(seg));
    chk({tag, "_dp"}, 32'(period), 32'(dp));
  endtask

  initial begin
    reset = 1'b1; Load = 1'b0; Sub = 1'b0; A = 8'h00; B = 8'h00;
    tick(2);
    chk("rst_sum", 32'(Sum), 32'h00);
    chk("rst_ovf", 32'(OverFlow), 32'h0);
    chk("rst_anodes", 32'(Anodes), 32'he);
    chk("rst_segs", 32'(segs7), 32'h40);
    chk("rst_period", 32'(period), 32'h1);
    reset = 1'b0;
    A = 8'h12; B = 8'h34;
    tick(6);
    chk("hold_sum", 32'(Sum), 32'h00);
    chk("hold_ovf", 32'(OverFlow), 32'h0);

    // 5 + 3 = 8
    load_op(8'h05, 8'h03, 1'b0);
    chk("add_sum", 32'(Sum), 32'h08);
    chk("add_ovf", 32'(OverFlow), 32'h0);
    tick(1);
    show("add_d0", 0, 7'h00, 1'b1);
    show("add_d1", 1, 7'h40, 1'b1);
    show("add_d2", 2, 7'h7F, 1'b1);
    show("add_d3", 3, 7'h7F, 1'b1);

    // 3 - 5 = -2
    load_op(8'h03, 8'h05, 1'b1);
    chk("sub_sum", 32'(Sum), 32'hFE);
    chk("sub_ovf", 32'(OverFlow), 32'h0);
    tick(1);
    show("sub_d0", 0, 7'h24, 1'b0);
    show("sub_d1", 1, 7'h40, 1'b1);

    // 127 + 1 overflows to -128, magnitude 0x80
    load_op(8'h7F, 8'h01, 1'b0);
    chk("ovp_sum", 32'(Sum), 32'h80);
    chk("ovp_ovf", 32'(OverFlow), 32'h1);
    tick(1);
    show("ovp_d0", 0, 7'h40, 1'b0);
    show("ovp_d1", 1, 7'h00, 1'b1);

    // -128 - 1 overflows to 127
    load_op(8'h80, 8'h01, 1'b1);
    chk("ovn_sum", 32'(Sum), 32'h7F);
    chk("ovn_ovf", 32'(OverFlow), 32'h1);
    tick(1);
    show("ovn_d0", 0, 7'h0E, 1'b1);
    show("ovn_d1", 1, 7'h78, 1'b1);

    // -1 + 1: carry out discarded, no signed overflow
    load_op(8'hFF, 8'h01, 1'b0);
    chk("carry_sum", 32'(Sum), 32'h00);
    chk("carry_ovf", 32'(OverFlow), 32'h0);

    // Operands change without Load: result holds
    A = 8'h40; B = 8'h40; Sub = 1'b0;
    tick(3);
    chk("noload_sum", 32'(Sum), 32'h00);

    // Reset with Load while digit 2 is active
    load_op(8'h21, 8'h01, 1'b0);
    chk("pre_rst_sum", 32'(Sum), 32'h22);
    show("pre_rst_d2", 2, 7'h7F, 1'b1);
    reset = 1'b1; Load = 1'b1; A = 8'h7F; B = 8'h7F;
    tick(1);
    reset = 1'b0; Load = 1'b0;
    chk("rl_sum", 32'(Sum), 32'h00);
    chk("rl_ovf", 32'(OverFlow), 32'h0);
    chk("rl_anodes", 32'(Anodes), 32'he);
    chk("rl_segs", 32'(segs7), 32'h40);
    chk("rl_period", 32'(period), 32'h1);
    // Prescaler restarted at 0: digit 0 lasts four more edges, then digit 1.
    tick(4);
    chk("rl_pre_hold", 32'(Anodes), 32'he);
    tick(1);
    chk("rl_pre_adv", 32'(Anodes), 32'hd);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
